// File: rtl/fir_decim_mc.sv
// fir_decim_mc: multichannel decimating FIR filter with one shared multiplier.
//
// One 16-bit sample per channel comes in on each accepted input vector. Each
// vector is written into a per-channel circular history. Every eff_ds-th
// accepted vector starts a filter pass. The pass steps through channel 0
// taps 0..eff_tap-1, then channel 1, and so on, one product per cycle. The
// sums are then rounded, shifted and saturated to 16 bits, and the result
// vector is presented on the output handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low. Ready never depends on valid.
//
// Ports
//   pcm_clk                       clock, rising edge
//   rst                           asynchronous reset, active low
//   pcm_in_valid / pcm_in_ready   input vector handshake
//   pcm_in  [16*CHANNEL]          signed samples, channel 0 at the LSBs
//   pcm_out_valid / pcm_out_ready output vector handshake
//   pcm_out [16*CHANNEL]          signed filtered samples
//   coef_wr/coef_addr/coef_data   coefficient write (shared by all channels)
//   coef_ready                    coefficient write accepted when high
//   tap_len [9]                   active taps, clamped to 1..MAX_TAP
//   down_sample [12]              decimation factor (0 behaves as 1)
//   pcm_out_shift [5]             rounding right shift
//   bypass                        pass input straight to output
//   flush                         clear history, decimation phase and write pointer
//   dbg_state_o [2]               current FSM state (0 IDLE,1 MAC,2 RND,3 OUT)
module fir_decim_mc #(
  parameter int CHANNEL = 4,
  parameter int MAX_TAP = 64,
  parameter int acw     = 40
) (
  input  logic                         pcm_clk,
  input  logic                         rst,
  input  logic                         pcm_in_valid,
  output logic                         pcm_in_ready,
  input  logic [16*CHANNEL-1:0]        pcm_in,
  output logic                         pcm_out_valid,
  input  logic                         pcm_out_ready,
  output logic [16*CHANNEL-1:0]        pcm_out,
  input  logic                         coef_wr,
  input  logic [$clog2(MAX_TAP)-1:0]   coef_addr,
  input  logic [15:0]                  coef_data,
  output logic                         coef_ready,
  input  logic [8:0]                   tap_len,
  input  logic [11:0]                  down_sample,
  input  logic [4:0]                   pcm_out_shift,
  input  logic                         bypass,
  input  logic                         flush,
  output logic [1:0]                   dbg_state_o
);

  localparam int AW = $clog2(MAX_TAP);
  localparam int CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNEL - 1);
  localparam logic [8:0] MAX_TAP9 = 9'(MAX_TAP);
  localparam logic signed [acw-1:0] ACC_ONE = 1;
  localparam logic signed [acw-1:0] SAT_MAX = 32767;
  localparam logic signed [acw-1:0] SAT_MIN = -32768;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_RND  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic signed [15:0]     coef_q [MAX_TAP];
  logic signed [15:0]     hist_q [CHANNEL][MAX_TAP];
  logic signed [acw-1:0]  acc_q  [CHANNEL];
  logic [AW-1:0]          wptr_q;
  logic [11:0]            dcnt_q;
  logic [8:0]             eff_tap_q;
  logic [4:0]             shift_q;
  logic [8:0]             tap_q;
  logic [CW-1:0]          ch_q;
  logic [16*CHANNEL-1:0]  pcm_out_q;

  logic                   accept;
  logic [11:0]            eff_ds;
  logic                   dcnt_last;
  logic                   go_mac;
  logic                   go_byp;
  logic                   tap_last;
  logic                   mac_last;
  logic [8:0]             eff_tap_in;
  logic [AW-1:0]          hist_idx;
  logic signed [31:0]     prod;
  logic signed [acw-1:0]  prod_ext;
  logic [16*CHANNEL-1:0]  rnd_vec;

  assign accept    = (state_q == S_IDLE) && pcm_in_valid && pcm_in_ready;
  assign eff_ds    = (down_sample == 12'd0) ? 12'd1 : down_sample;
  // >= rather than == so a factor lowered mid-count still wraps promptly.
  assign dcnt_last = (dcnt_q >= eff_ds - 12'd1);
  assign go_byp    = accept && bypass;
  assign go_mac    = accept && !bypass && dcnt_last;
  assign tap_last  = (tap_q == eff_tap_q - 9'd1);
  assign mac_last  = tap_last && (ch_q == LAST_CH);

  assign eff_tap_in = (tap_len == 9'd0)     ? 9'd1 :
                      (tap_len > MAX_TAP9)  ? MAX_TAP9 : tap_len;

  // Newest sample sits at wptr-1; tap i reads i samples further back.
  assign hist_idx = wptr_q - AW'(1) - tap_q[AW-1:0];
  assign prod     = coef_q[tap_q[AW-1:0]] * hist_q[ch_q][hist_idx];
  assign prod_ext = $signed({{(acw-32){prod[31]}}, prod});

  // Round half up, arithmetic shift, then saturate each channel to 16 bits.
  always_comb begin
    rnd_vec = '0;
    for (int c = 0; c < CHANNEL; c++) begin
      logic signed [acw-1:0] y_v;
      logic signed [acw-1:0] r_v;
      y_v = acc_q[c];
      if (shift_q == 5'd0) r_v = y_v;
      else                 r_v = (y_v + (ACC_ONE <<< (shift_q - 5'd1))) >>> shift_q;
      if (r_v > SAT_MAX)      rnd_vec[16*c +: 16] = 16'h7fff;
      else if (r_v < SAT_MIN) rnd_vec[16*c +: 16] = 16'h8000;
      else                    rnd_vec[16*c +: 16] = r_v[15:0];
    end
  end

  // State register
  always_ff @(posedge pcm_clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go_byp)      state_d = S_OUT;
        else if (go_mac) state_d = S_MAC;
      end
      S_MAC:   if (mac_last) state_d = S_RND;
      S_RND:   state_d = S_OUT;
      S_OUT:   if (pcm_out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; both readies are forced low while reset is asserted.
  always_comb begin
    pcm_out_valid = (state_q == S_OUT);
    pcm_in_ready  = rst && (state_q == S_IDLE) && !flush;
    coef_ready    = rst && (state_q != S_MAC);
    pcm_out       = pcm_out_q;
    dbg_state_o   = state_q;
  end

  // Datapath
  always_ff @(posedge pcm_clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < MAX_TAP; t++) coef_q[t] <= '0;
      for (int c = 0; c < CHANNEL; c++) begin
        for (int t = 0; t < MAX_TAP; t++) hist_q[c][t] <= '0;
        acc_q[c] <= '0;
      end
      wptr_q    <= '0;
      dcnt_q    <= '0;
      eff_tap_q <= 9'd1;
      shift_q   <= '0;
      tap_q     <= '0;
      ch_q      <= '0;
      pcm_out_q <= '0;
    end else begin
      if (coef_wr && coef_ready) coef_q[coef_addr] <= coef_data;

      // Flush and accept are exclusive: pcm_in_ready is low while flush is high.
      if (state_q == S_IDLE && flush) begin
        for (int c = 0; c < CHANNEL; c++)
          for (int t = 0; t < MAX_TAP; t++) hist_q[c][t] <= '0;
        wptr_q <= '0;
        dcnt_q <= '0;
      end else if (accept) begin
        for (int c = 0; c < CHANNEL; c++) hist_q[c][wptr_q] <= pcm_in[16*c +: 16];
        wptr_q <= wptr_q + AW'(1);
        if (bypass) begin
          pcm_out_q <= pcm_in;
        end else begin
          dcnt_q <= dcnt_last ? 12'd0 : dcnt_q + 12'd1;
        end
        if (go_mac) begin
          eff_tap_q <= eff_tap_in;
          shift_q   <= pcm_out_shift;
          tap_q     <= '0;
          ch_q      <= '0;
          for (int c = 0; c < CHANNEL; c++) acc_q[c] <= '0;
        end
      end

      if (state_q == S_MAC) begin
        acc_q[ch_q] <= acc_q[ch_q] + prod_ext;
        if (tap_last) begin
          tap_q <= '0;
          if (ch_q != LAST_CH) ch_q <= ch_q + CW'(1);
        end else begin
          tap_q <= tap_q + 9'd1;
        end
      end

      if (state_q == S_RND) pcm_out_q <= rnd_vec;
    end
  end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Testbench for fir_decim_mc (CHANNEL=4, MAX_TAP=64, acw=40) with
// hand-computed expected output vectors and a queue-based output checker.
module tb_fir_decim_mc;

  localparam int W = 64;

  logic          pcm_clk = 1'b0;
  logic          rst = 1'b0;
  logic          pcm_in_valid = 1'b0;
  logic          pcm_in_ready;
  logic [W-1:0]  pcm_in = '0;
  logic          pcm_out_valid;
  logic          pcm_out_ready = 1'b1;
  logic [W-1:0]  pcm_out;
  logic          coef_wr = 1'b0;
  logic [5:0]    coef_addr = '0;
  logic [15:0]   coef_data = '0;
  logic          coef_ready;
  logic [8:0]    tap_len = 9'd1;
  logic [11:0]   down_sample = 12'd1;
  logic [4:0]    pcm_out_shift = '0;
  logic          bypass = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    dbg_state;

  fir_decim_mc #(.CHANNEL(4), .MAX_TAP(64), .acw(40)) dut (
    .pcm_clk       (pcm_clk),
    .rst           (rst),
    .pcm_in_valid  (pcm_in_valid),
    .pcm_in_ready  (pcm_in_ready),
    .pcm_in        (pcm_in),
    .pcm_out_valid (pcm_out_valid),
    .pcm_out_ready (pcm_out_ready),
    .pcm_out       (pcm_out),
    .coef_wr       (coef_wr),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .coef_ready    (coef_ready),
    .tap_len       (tap_len),
    .down_sample   (down_sample),
    .pcm_out_shift (pcm_out_shift),
    .bypass        (bypass),
    .flush         (flush),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 pcm_clk = ~pcm_clk;

  int cyc = 0;
  always @(posedge pcm_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];   // expected transfer edge, -1 = not checked

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  logic [W-1:0] mon_e;
  int           mon_t;
  always @(negedge pcm_clk) begin
    #2;
    if (rst && pcm_out_valid && pcm_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", pcm_out);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_cyc_q.pop_front();
        chk("out_data", pcm_out, mon_e);
        if (mon_t >= 0) chk("out_cycle", W'(cyc + 1), W'(mon_t));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] vec, input bit push,
                      input logic [W-1:0] expv, input int lat);
    int n;
    bit got;
    @(negedge pcm_clk);
    pcm_in = vec;
    pcm_in_valid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 400) begin
      #1;
      if (pcm_in_ready) begin
        if (push) begin
          exp_q.push_back(expv);
          exp_cyc_q.push_back((lat < 0) ? -1 : cyc + 1 + lat);
        end
        @(posedge pcm_clk);
        #1;
        pcm_in_valid = 1'b0;
        got = 1'b1;
      end else begin
        @(negedge pcm_clk);
        n++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      pcm_in_valid = 1'b0;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data);
    @(negedge pcm_clk);
    coef_wr = 1'b1;
    coef_addr = 6'(addr);
    coef_data = data;
    @(negedge pcm_clk);
    coef_wr = 1'b0;
  endtask

  task automatic cfg(input int taps, input int sh, input int ds);
    @(negedge pcm_clk);
    tap_len = 9'(taps);
    pcm_out_shift = 5'(sh);
    down_sample = 12'(ds);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge pcm_clk);
      n++;
    end
    #3;
    chk("drain", W'(exp_q.size()), W'(0));
  endtask

  task automatic do_flush();
    @(negedge pcm_clk);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", W'(pcm_in_ready), W'(0));
    @(negedge pcm_clk);
    flush = 1'b0;
  endtask

  // Impulse on channel 0 through taps 1..8: outputs 1..8 then 0, 34 edges after accept.
  task automatic run_impulse();
    for (int k = 0; k < 8; k++) write_coef(k, 16'(k + 1));
    cfg(8, 0, 1);
    for (int i = 0; i < 10; i++) begin
      send((i == 0) ? W'(1) : W'(0), 1'b1, (i < 8) ? W'(i + 1) : W'(0), 34);
    end
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] bp_a;

  initial begin
    // Reset state
    repeat (3) @(negedge pcm_clk);
    #1;
    chk("rst_out_valid", W'(pcm_out_valid), W'(0));
    chk("rst_pcm_out", pcm_out, W'(0));
    chk("rst_in_ready", W'(pcm_in_ready), W'(0));
    chk("rst_coef_ready", W'(coef_ready), W'(0));
    chk("rst_state", W'(dbg_state), W'(0));
    rst = 1'b1;
    @(posedge pcm_clk);
    @(negedge pcm_clk);
    #1;
    chk("post_rst_in_ready", W'(pcm_in_ready), W'(1));
    chk("post_rst_coef_ready", W'(coef_ready), W'(1));

    // Impulse response
    run_impulse();

    // Multi-channel, 3 taps (coef 1,2,3), down_sample 0 behaves as 1, latency 3*4+2
    do_flush();
    cfg(3, 0, 0);
    send(64'h0000_0064_fffb_000a, 1'b1, 64'h0000_0064_fffb_000a, 14);
    send(64'h0007_ff9c_0002_0001, 1'b1, 64'h0007_0064_fff8_0015, 14);
    send(64'h0000_0000_0000_0000, 1'b1, 64'h000e_0064_fff5_0020, 14);
    wait_drain();

    // Decimation by 4, one tap: output only on every 4th accept
    do_flush();
    cfg(1, 0, 4);
    for (int i = 0; i < 8; i++) begin
      send({4{16'd100}}, (i % 4) == 3, {4{16'd100}}, 6);
    end
    wait_drain();

    // Saturation both ways
    do_flush();
    for (int k = 0; k < 8; k++) write_coef(k, 16'h7fff);
    cfg(8, 13, 1);
    for (int i = 0; i < 8; i++) begin
      send(64'h7fff_7fff_8000_7fff, 1'b1, 64'h7fff_7fff_8000_7fff, 34);
    end
    wait_drain();

    // Rounding, shift 1; tap_len 0 clamps to one tap (history is non-zero here)
    write_coef(0, 16'd1);
    cfg(0, 1, 1);
    send(64'hfffc_0005_0003_fffd, 1'b1, 64'hfffe_0003_0002_ffff, 6);
    wait_drain();

    // Backpressure: y = x[n] + x[n-1]
    do_flush();
    write_coef(1, 16'd1);
    cfg(2, 0, 1);
    bp_a = 64'h002c_0021_0016_000b;
    @(negedge pcm_clk);
    pcm_out_ready = 1'b0;
    send(bp_a, 1'b1, bp_a, -1);
    begin
      int n;
      n = 0;
      while (!pcm_out_valid && n < 40) begin
        @(negedge pcm_clk);
        #1;
        n++;
      end
      chk("bp_valid_seen", W'(pcm_out_valid), W'(1));
    end
    @(negedge pcm_clk);
    pcm_in = 64'h0004_0003_0002_0001;
    pcm_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge pcm_clk);
      #1;
      chk("bp_hold_data", pcm_out, bp_a);
      chk("bp_hold_flags", W'({pcm_out_valid, pcm_in_ready}), W'(2'b10));
    end
    @(negedge pcm_clk);
    pcm_out_ready = 1'b1;
    send(64'h0004_0003_0002_0001, 1'b1, 64'h0030_0024_0018_000c, -1);
    send(64'h0000_0000_0000_0064, 1'b1, 64'h0004_0003_0002_0065, -1);
    wait_drain();

    // Reset during the 5th MAC cycle
    for (int k = 0; k < 8; k++) write_coef(k, 16'(k + 1));
    cfg(8, 0, 1);
    send(64'h0000_0000_0000_01f4, 1'b0, '0, 0);
    repeat (4) @(posedge pcm_clk);
    @(negedge pcm_clk);
    chk("mid_mac_state", W'(dbg_state), W'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", W'(pcm_out_valid), W'(0));
    chk("mid_rst_state", W'(dbg_state), W'(0));
    repeat (3) @(negedge pcm_clk);
    chk("mid_rst_coef_ready", W'(coef_ready), W'(0));
    rst = 1'b1;
    repeat (40) @(negedge pcm_clk);
    #1;
    chk("after_rst_valid", W'(pcm_out_valid), W'(0));
    run_impulse();

    // Bypass: output equals input one edge later
    @(negedge pcm_clk);
    bypass = 1'b1;
    send(64'h1234_8000_7fff_0001, 1'b1, 64'h1234_8000_7fff_0001, 1);
    send(64'hdead_beef_0000_ffff, 1'b1, 64'hdead_beef_0000_ffff, 1);
    send(64'h0001_0002_0003_0004, 1'b1, 64'h0001_0002_0003_0004, 1);
    wait_drain();
    @(negedge pcm_clk);
    bypass = 1'b0;

    // Flush, then impulse must show no residue of the bypassed samples
    do_flush();
    run_impulse();

    repeat (5) @(negedge pcm_clk);
    chk("final_queue_empty", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
